// File: rtl/reg_writeback_if.sv
// reg_writeback bus bundle: ALU, issue and long-latency
// handshakes plus the register-file write port and status.
interface reg_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int QDEPTH = 2
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_ready;
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_rd;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic              Reg_write;
  logic [ADDR_W-1:0] Rd;
  logic [DATA_W-1:0] write_data;
  logic [31:0]       pending;
  logic [CW-1:0]     q_count;
  logic              err;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output issue_valid, issue_rd,
    output lu_valid, lu_rd, lu_data,
    input  alu_ready, issue_ready, lu_ready,
    input  Reg_write, Rd, write_data,
    input  pending, q_count, err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  issue_valid, issue_rd,
    input  lu_valid, lu_rd, lu_data,
    output alu_ready, issue_ready, lu_ready,
    output Reg_write, Rd, write_data,
    output pending, q_count, err
  );
endinterface

// File: rtl/reg_writeback.sv
// Register-file write arbiter: ALU path, long-latency queue
// and the pending-write scoreboard used for RAW stalls.
module reg_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_writeback_if.slave  bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] qrd_q  [QDEPTH];
  logic [DATA_W-1:0] qdat_q [QDEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       pend_q, pend_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  logic              full;
  logic              alu_xfer;
  logic              lu_xfer;
  logic              iss_xfer;
  logic              deq;
  logic              sel_v;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  assign head_rd   = qrd_q[rptr_q];
  assign head_data = qdat_q[rptr_q];

  // Handshakes and write-port arbitration; a full queue
  // always drains first so long-latency units never starve.
  always_comb begin
    full     = (cnt_q == CW'(QDEPTH));
    alu_xfer = bus.alu_valid & ~full;
    lu_xfer  = bus.lu_valid & ~full;
    iss_xfer = bus.issue_valid & ~pend_q[bus.issue_rd];
    deq      = full | (~alu_xfer & (cnt_q != '0));
    sel_v    = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    unique case (1'b1)
      deq: begin
        sel_v    = 1'b1;
        sel_rd   = head_rd;
        sel_data = head_data;
      end
      alu_xfer: begin
        sel_v    = 1'b1;
        sel_rd   = bus.alu_rd;
        sel_data = bus.alu_data;
      end
      default: ;
    endcase
  end

  // Next state for write port, queue, scoreboard and error.
  always_comb begin
    we_d   = sel_v & (sel_rd != '0);
    rd_d   = we_d ? sel_rd : rd_q;
    wd_d   = we_d ? sel_data : wd_q;
    wptr_d = wptr_q + PW'(lu_xfer);
    rptr_d = rptr_q + PW'(deq);
    cnt_d  = cnt_q + CW'(lu_xfer) - CW'(deq);
    pend_d = pend_q;
    if (deq)
      pend_d[head_rd] = 1'b0;
    if (iss_xfer)
      pend_d[bus.issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
    err_d = err_q;
    if (lu_xfer && bus.lu_rd != '0 && !pend_q[bus.lu_rd])
      err_d = 1'b1;
    if (alu_xfer && bus.alu_rd != '0 && pend_q[bus.alu_rd])
      err_d = 1'b1;
  end

  // Control and write-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      wd_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      wd_q   <= wd_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  // Queue storage, written at the tail on each LU transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        qrd_q[i]  <= '0;
        qdat_q[i] <= '0;
      end
    end else if (lu_xfer) begin
      qrd_q[wptr_q]  <= bus.lu_rd;
      qdat_q[wptr_q] <= bus.lu_data;
    end
  end

  assign bus.alu_ready   = ~full;
  assign bus.lu_ready    = ~full;
  assign bus.issue_ready = ~pend_q[bus.issue_rd];
  assign bus.Reg_write   = we_q;
  assign bus.Rd          = rd_q;
  assign bus.write_data  = wd_q;
  assign bus.pending     = pend_q;
  assign bus.q_count     = cnt_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: ALU vector table, scoreboard of
// expected register-file writes and multi-cycle sequences.
module tb_reg_writeback;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  reg_writeback_if #(.DATA_W(32), .ADDR_W(5), .QDEPTH(2)) bus ();

  reg_writeback #(.DATA_W(32), .ADDR_W(5), .QDEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic [4:0]  erd;
    logic [31:0] edata;
  } vec_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.lu_valid    = 1'b0;
    bus.lu_rd       = '0;
    bus.lu_data     = '0;
  endtask

  task automatic expect_wr(logic [4:0] rd, logic [31:0] d);
    wr_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic issue(logic [4:0] rd);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = rd;
    #1;
    chk("issue_ready", bus.issue_ready, 1);
    tick();
    bus.issue_valid = 1'b0;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_we"}, bus.Reg_write, 0);
    chk({tag, "_rd"}, bus.Rd, 0);
    chk({tag, "_wd"}, bus.write_data, 0);
    chk({tag, "_pend"}, bus.pending, 0);
    chk({tag, "_qcnt"}, bus.q_count, 0);
    chk({tag, "_err"}, bus.err, 0);
  endtask

  // Every register-file write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.Reg_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd %0d data %0h required none",
                 bus.Rd, bus.write_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_rd", bus.Rd, e.rd);
        chk("sb_data", bus.write_data, e.data);
      end
    end
  end

  vec_t v[4];

  initial begin
    v[0] = '{5'd5,  32'h1234,     1'b1, 5'd5,  32'h1234};
    v[1] = '{5'd0,  32'hdead,     1'b0, 5'd5,  32'h1234};
    v[2] = '{5'd31, 32'hffffffff, 1'b1, 5'd31, 32'hffffffff};
    v[3] = '{5'd1,  32'h0,        1'b1, 5'd1,  32'h0};

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU-only vectors, result visible one cycle later
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = v[i].rd;
      bus.alu_data  = v[i].data;
      if (v[i].we)
        expect_wr(v[i].rd, v[i].data);
      #1;
      chk("alu_ready", bus.alu_ready, 1);
      tick();
      chk("vec_we", bus.Reg_write, v[i].we);
      chk("vec_rd", bus.Rd, v[i].erd);
      chk("vec_wd", bus.write_data, v[i].edata);
    end
    idle();
    tick();
    chk("idle_we", bus.Reg_write, 0);

    // Scoreboard set, RAW stall and clear on write
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    #1;
    chk("iss7_ready", bus.issue_ready, 1);
    tick();
    chk("pend7_set", bus.pending[7], 1);
    chk("iss7_stall", bus.issue_ready, 0);
    bus.issue_valid = 1'b0;
    bus.lu_valid = 1'b1;
    bus.lu_rd    = 5'd7;
    bus.lu_data  = 32'hAA;
    expect_wr(5'd7, 32'hAA);
    #1;
    chk("lu7_ready", bus.lu_ready, 1);
    tick();
    bus.lu_valid = 1'b0;
    chk("lu7_n1_we", bus.Reg_write, 0);
    chk("lu7_n1_q", bus.q_count, 1);
    chk("lu7_n1_pend", bus.pending[7], 1);
    tick();
    chk("lu7_n2_we", bus.Reg_write, 1);
    chk("lu7_n2_pend", bus.pending[7], 0);
    chk("lu7_n2_q", bus.q_count, 0);
    bus.issue_rd = 5'd7;
    #1;
    chk("iss7_reopen", bus.issue_ready, 1);

    // Contention between ALU stream and queued results
    issue(5'd3);
    issue(5'd9);
    expect_wr(5'd4, 32'h44);
    expect_wr(5'd6, 32'h66);
    expect_wr(5'd3, 32'h33);
    expect_wr(5'd8, 32'h88);
    expect_wr(5'd9, 32'h99);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
    bus.lu_valid  = 1'b1; bus.lu_rd  = 5'd3; bus.lu_data  = 32'h33;
    tick();
    chk("ct_a_q", bus.q_count, 1);
    bus.alu_rd = 5'd6; bus.alu_data = 32'h66;
    bus.lu_rd  = 5'd9; bus.lu_data  = 32'h99;
    tick();
    chk("ct_b_q", bus.q_count, 2);
    chk("ct_b_rd", bus.Rd, 6);
    bus.alu_rd = 5'd8; bus.alu_data = 32'h88;
    bus.lu_valid = 1'b0;
    #1;
    chk("ct_c_alu_rdy", bus.alu_ready, 0);
    chk("ct_c_lu_rdy", bus.lu_ready, 0);
    tick();
    chk("ct_c_rd", bus.Rd, 3);
    chk("ct_c_q", bus.q_count, 1);
    #1;
    chk("ct_d_alu_rdy", bus.alu_ready, 1);
    tick();
    bus.alu_valid = 1'b0;
    chk("ct_d_rd", bus.Rd, 8);
    tick();
    chk("ct_e_rd", bus.Rd, 9);
    chk("ct_e_q", bus.q_count, 0);
    chk("ct_e_pend", bus.pending, 0);
    chk("ct_e_err", bus.err, 0);

    // Full queue with LU held, then dequeue+enqueue together
    issue(5'd10);
    issue(5'd11);
    issue(5'd13);
    expect_wr(5'd20, 32'h1020);
    expect_wr(5'd21, 32'h1021);
    expect_wr(5'd10, 32'h1010);
    expect_wr(5'd11, 32'h1011);
    expect_wr(5'd13, 32'h1013);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'h1020;
    bus.lu_valid  = 1'b1; bus.lu_rd  = 5'd10; bus.lu_data  = 32'h1010;
    tick();
    bus.alu_rd = 5'd21; bus.alu_data = 32'h1021;
    bus.lu_rd  = 5'd11; bus.lu_data  = 32'h1011;
    tick();
    chk("fq_full", bus.q_count, 2);
    bus.alu_valid = 1'b0;
    bus.lu_rd = 5'd13; bus.lu_data = 32'h1013;
    #1;
    chk("fq_lu_rdy0", bus.lu_ready, 0);
    chk("fq_alu_rdy0", bus.alu_ready, 0);
    tick();
    chk("fq_g_q", bus.q_count, 1);
    chk("fq_g_rd", bus.Rd, 10);
    #1;
    chk("fq_lu_rdy1", bus.lu_ready, 1);
    tick();
    bus.lu_valid = 1'b0;
    chk("fq_h_q", bus.q_count, 1);
    chk("fq_h_rd", bus.Rd, 11);
    tick();
    chk("fq_i_q", bus.q_count, 0);
    chk("fq_i_rd", bus.Rd, 13);

    // LU result to non-pending register raises err
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd12; bus.lu_data = 32'hC;
    expect_wr(5'd12, 32'hC);
    tick();
    bus.lu_valid = 1'b0;
    chk("err_lu", bus.err, 1);
    tick();
    chk("err_lu_wr", bus.Rd, 12);

    // Reset in the middle of traffic with two queued entries
    issue(5'd16);
    issue(5'd17);
    expect_wr(5'd25, 32'h25);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd25; bus.alu_data = 32'h25;
    bus.lu_valid  = 1'b1; bus.lu_rd  = 5'd16; bus.lu_data  = 32'h16;
    tick();
    bus.alu_rd = 5'd26; bus.alu_data = 32'h26;
    bus.lu_rd  = 5'd17; bus.lu_data  = 32'h17;
    tick();
    chk("mr_q2", bus.q_count, 2);
    chk("mr_err", bus.err, 1);
    rst_n = 1'b0;
    idle();
    #1;
    chk_reset("rst_mid");
    exp_q.delete();
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_reset("rst_rel");

    // ALU write to a pending register (WAW) raises err
    issue(5'd15);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd15; bus.alu_data = 32'hF;
    expect_wr(5'd15, 32'hF);
    #1;
    chk("waw_alu_rdy", bus.alu_ready, 1);
    tick();
    bus.alu_valid = 1'b0;
    chk("err_waw", bus.err, 1);
    chk("waw_we", bus.Reg_write, 1);
    chk("waw_rd", bus.Rd, 15);
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd15; bus.lu_data = 32'hF2;
    expect_wr(5'd15, 32'hF2);
    tick();
    bus.lu_valid = 1'b0;
    tick();
    tick();
    chk("err_sticky", bus.err, 1);
    chk("end_pend", bus.pending, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
